// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: gathers dot/line pulses into a symbol buffer, closes a
// letter after GAP_TICKS idle ticks and emits the A-Z index or an error pulse.
module morse_letter_decoder #(
    parameter int GAP_TICKS = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ld_dot,
    input  logic       ld_line,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       busy,
    output logic [2:0] sym_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

    logic [1:0]       state;
    logic [3:0]       pattern;
    logic [CNT_W-1:0] idle_cnt;
    logic             sym_edge;
    logic             both_in;
    logic [5:0]       dec;

    assign sym_edge = ld_dot ^ ld_line;
    assign both_in  = ld_dot & ld_line;

    // Returns {valid, index}; pattern holds the first symbol in bit n-1.
    function automatic logic [5:0] decode(input logic [2:0] n, input logic [3:0] p);
        logic [5:0] r;
        r = 6'd0;
        case (n)
            3'd1: r = p[0] ? {1'b1, 5'd19} : {1'b1, 5'd4};
            3'd2: case (p[1:0])
                2'b00:   r = {1'b1, 5'd8};
                2'b01:   r = {1'b1, 5'd0};
                2'b10:   r = {1'b1, 5'd13};
                default: r = {1'b1, 5'd12};
            endcase
            3'd3: case (p[2:0])
                3'b000:  r = {1'b1, 5'd18};
                3'b001:  r = {1'b1, 5'd20};
                3'b010:  r = {1'b1, 5'd17};
                3'b011:  r = {1'b1, 5'd22};
                3'b100:  r = {1'b1, 5'd3};
                3'b101:  r = {1'b1, 5'd10};
                3'b110:  r = {1'b1, 5'd6};
                default: r = {1'b1, 5'd14};
            endcase
            3'd4: case (p)
                4'b0000: r = {1'b1, 5'd7};
                4'b0001: r = {1'b1, 5'd21};
                4'b0010: r = {1'b1, 5'd5};
                4'b0100: r = {1'b1, 5'd11};
                4'b0110: r = {1'b1, 5'd15};
                4'b0111: r = {1'b1, 5'd9};
                4'b1000: r = {1'b1, 5'd1};
                4'b1001: r = {1'b1, 5'd23};
                4'b1010: r = {1'b1, 5'd2};
                4'b1011: r = {1'b1, 5'd24};
                4'b1100: r = {1'b1, 5'd25};
                4'b1101: r = {1'b1, 5'd16};
                default: r = 6'd0;
            endcase
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    assign dec = decode(sym_count, pattern);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            pattern      <= 4'd0;
            sym_count    <= 3'd0;
            idle_cnt     <= '0;
            letter       <= 5'd0;
            letter_valid <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sym_edge) begin
                        pattern   <= {3'b000, ld_line};
                        sym_count <= 3'd1;
                        idle_cnt  <= '0;
                        state     <= S_COLLECT;
                        busy      <= 1'b1;
                    end else if (both_in) begin
                        idle_cnt <= '0;
                        state    <= S_DISCARD;
                        busy     <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    // A symbol on the closing edge takes priority over decoding.
                    if (both_in || (sym_edge && sym_count == 3'd4)) begin
                        idle_cnt <= '0;
                        state    <= S_DISCARD;
                    end else if (sym_edge) begin
                        pattern   <= {pattern[2:0], ld_line};
                        sym_count <= sym_count + 3'd1;
                        idle_cnt  <= '0;
                    end else if (idle_cnt == GAP_LAST) begin
                        if (dec[5]) begin
                            letter       <= dec[4:0];
                            letter_valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        pattern   <= 4'd0;
                        sym_count <= 3'd0;
                        idle_cnt  <= '0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (sym_edge || both_in) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == GAP_LAST) begin
                        error     <= 1'b1;
                        pattern   <= 4'd0;
                        sym_count <= 3'd0;
                        idle_cnt  <= '0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
